// File: rtl/scan_chain_ctrl.sv
// Two-phase configuration scan chain sequencer: serialises a parallel word into the
// chain (then strobes load) or captures the chain and shifts it back out into rd_data.
//
// state | meaning
// IDLE  | waiting for start
// SETUP | both clocks low, scan_in/scan_i0o1 presented for this bit period
// PHI   | master clock high
// HOLD  | both clocks low between phases
// PHIB  | slave clock high
// TAIL  | final non-overlap gap after the last bit period
// LOAD  | shadow-register update strobe (write only)
// DONE  | one-cycle completion pulse
module scan_chain_ctrl #(
    parameter int CHAIN_LEN = 64,
    parameter int PH_W      = 2,
    parameter int GAP_W     = 1,
    parameter int LOAD_W    = 2
) (
    input  logic                 clk_signal_ext,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 mode,
    input  logic [CHAIN_LEN-1:0] wr_data,
    output logic [CHAIN_LEN-1:0] rd_data,
    output logic                 busy,
    output logic                 done,
    output logic                 phi,
    output logic                 phib,
    output logic                 scan_i0o1,
    output logic                 load,
    output logic                 scan_in,
    input  logic                 scan_out
);

    localparam int MAX_PW = (PH_W > GAP_W) ? ((PH_W > LOAD_W) ? PH_W : LOAD_W)
                                           : ((GAP_W > LOAD_W) ? GAP_W : LOAD_W);
    localparam int PC_W   = (MAX_PW > 1) ? $clog2(MAX_PW) : 1;
    localparam int BC_W   = $clog2(CHAIN_LEN + 1);

    localparam logic [PC_W-1:0] PH_LAST   = PC_W'(PH_W - 1);
    localparam logic [PC_W-1:0] GAP_LAST  = PC_W'(GAP_W - 1);
    localparam logic [PC_W-1:0] LOAD_LAST = PC_W'(LOAD_W - 1);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] SETUP = 3'd1;
    localparam logic [2:0] PHI   = 3'd2;
    localparam logic [2:0] HOLD  = 3'd3;
    localparam logic [2:0] PHIB  = 3'd4;
    localparam logic [2:0] TAIL  = 3'd5;
    localparam logic [2:0] LOAD  = 3'd6;
    localparam logic [2:0] DONE  = 3'd7;

    logic [2:0]           state, state_n;
    logic [PC_W-1:0]      ph_cnt, ph_n, ph_inc;
    logic [BC_W-1:0]      bit_cnt, bit_n, last_bit;
    logic                 mode_q, mode_n;
    logic [CHAIN_LEN-1:0] shreg, sh_n;
    logic                 in_period;

    assign ph_inc   = ph_cnt + 1'b1;
    // read mode has one extra (capture) period ahead of the CHAIN_LEN shifts
    assign last_bit = mode_q ? BC_W'(CHAIN_LEN) : BC_W'(CHAIN_LEN - 1);

    always_comb begin
        state_n = state;
        ph_n    = ph_cnt;
        bit_n   = bit_cnt;
        mode_n  = mode_q;
        sh_n    = shreg;
        case (state)
            IDLE: begin
                if (start) begin
                    state_n = SETUP;
                    ph_n    = '0;
                    bit_n   = '0;
                    mode_n  = mode;
                    sh_n    = mode ? '0 : wr_data;
                end
            end
            SETUP: begin
                if (ph_cnt == '0 && mode_q && bit_cnt != '0)
                    sh_n = {shreg[CHAIN_LEN-2:0], scan_out};
                if (ph_cnt == GAP_LAST) begin
                    state_n = PHI;
                    ph_n    = '0;
                end else begin
                    ph_n = ph_inc;
                end
            end
            PHI: begin
                if (ph_cnt == PH_LAST) begin
                    state_n = HOLD;
                    ph_n    = '0;
                end else begin
                    ph_n = ph_inc;
                end
            end
            HOLD: begin
                if (ph_cnt == GAP_LAST) begin
                    state_n = PHIB;
                    ph_n    = '0;
                end else begin
                    ph_n = ph_inc;
                end
            end
            PHIB: begin
                if (ph_cnt == PH_LAST) begin
                    ph_n = '0;
                    if (bit_cnt == last_bit) begin
                        state_n = TAIL;
                        bit_n   = '0;
                    end else begin
                        state_n = SETUP;
                        bit_n   = bit_cnt + 1'b1;
                        if (!mode_q)
                            sh_n = {shreg[CHAIN_LEN-2:0], 1'b0};
                    end
                end else begin
                    ph_n = ph_inc;
                end
            end
            TAIL: begin
                if (ph_cnt == GAP_LAST) begin
                    state_n = mode_q ? DONE : LOAD;
                    ph_n    = '0;
                end else begin
                    ph_n = ph_inc;
                end
            end
            LOAD: begin
                if (ph_cnt == LOAD_LAST) begin
                    state_n = DONE;
                    ph_n    = '0;
                end else begin
                    ph_n = ph_inc;
                end
            end
            DONE: begin
                state_n = IDLE;
                ph_n    = '0;
            end
            default: begin
                state_n = IDLE;
                ph_n    = '0;
                bit_n   = '0;
            end
        endcase
    end

    assign in_period = (state_n == SETUP) || (state_n == PHI) ||
                       (state_n == HOLD)  || (state_n == PHIB);

    // outputs are decoded from the next state so they register in step with it
    always_ff @(posedge clk_signal_ext) begin
        if (rst) begin
            state     <= IDLE;
            ph_cnt    <= '0;
            bit_cnt   <= '0;
            mode_q    <= 1'b0;
            shreg     <= '0;
            rd_data   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            phi       <= 1'b0;
            phib      <= 1'b0;
            scan_i0o1 <= 1'b0;
            load      <= 1'b0;
            scan_in   <= 1'b0;
        end else begin
            state     <= state_n;
            ph_cnt    <= ph_n;
            bit_cnt   <= bit_n;
            mode_q    <= mode_n;
            shreg     <= sh_n;
            busy      <= (state_n != IDLE) && (state_n != DONE);
            done      <= (state_n == DONE);
            phi       <= (state_n == PHI);
            phib      <= (state_n == PHIB);
            load      <= (state_n == LOAD);
            scan_in   <= in_period && !mode_n && sh_n[CHAIN_LEN-1];
            scan_i0o1 <= in_period && mode_n && (bit_n == '0);
            if (state_n == DONE && mode_q)
                rd_data <= shreg;
        end
    end

endmodule

// File: tb/tb_scan_chain_ctrl.sv
// Directed bench for scan_chain_ctrl with a behavioural two-phase scan chain model.
module tb_scan_chain_ctrl;

    localparam int N = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         mode;
    logic [N-1:0] wr_data;
    logic [N-1:0] rd_data;
    logic         busy, done, phi, phib, scan_i0o1, load, scan_in, scan_out;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    scan_chain_ctrl #(.CHAIN_LEN(N), .PH_W(2), .GAP_W(1), .LOAD_W(2)) dut (
        .clk_signal_ext(clk),
        .rst           (rst),
        .start         (start),
        .mode          (mode),
        .wr_data       (wr_data),
        .rd_data       (rd_data),
        .busy          (busy),
        .done          (done),
        .phi           (phi),
        .phib          (phib),
        .scan_i0o1     (scan_i0o1),
        .load          (load),
        .scan_in       (scan_in),
        .scan_out      (scan_out)
    );

    // two-phase chain: master follows on phi, slave on phib, shadow on load
    logic [N-1:0] m_master, m_slave, shadow, par_in;
    assign scan_out = m_slave[N-1];

    always @(posedge clk) begin
        if (rst) begin
            m_master <= '0;
            m_slave  <= '0;
            shadow   <= '0;
        end else begin
            if (phi)  m_master <= scan_i0o1 ? par_in : {m_slave[N-2:0], scan_in};
            if (phib) m_slave  <= m_master;
            if (load) shadow   <= m_slave;
        end
    end

    // protocol monitor, summarised into checks at the end
    int   v_overlap = 0, v_stable = 0, v_done = 0;
    logic p_si = 1'b0, p_sel = 1'b0, p_done = 1'b0;

    always @(negedge clk) begin
        if (!rst) begin
            if (phi && phib) v_overlap++;
            if ((phi || phib) && (scan_in != p_si || scan_i0o1 != p_sel)) v_stable++;
            if (done && p_done) v_done++;
        end
        p_si   = scan_in;
        p_sel  = scan_i0o1;
        p_done = done;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] msk(input int lo, input int hi);
        logic [63:0] r;
        for (int i = 0; i < 64; i++) r[i] = (i >= lo) && (i <= hi);
        return r;
    endfunction

    logic [63:0] t_busy, t_done, t_phi, t_phib, t_load, t_si, t_sel;
    logic [N-1:0] rd_tr [0:63];

    // cycle 0 carries start; samples k=1..n are taken mid-cycle
    task automatic run(input logic m, input logic [N-1:0] d, input int n,
                       input int s_a, input int s_b, input int s_b_end, input int rst_at);
        t_busy = '0; t_done = '0; t_phi = '0; t_phib = '0;
        t_load = '0; t_si = '0; t_sel = '0;
        @(negedge clk);
        start = 1'b1; mode = m; wr_data = d;
        for (int k = 1; k <= n; k++) begin
            @(negedge clk);
            t_busy[k] = busy;  t_done[k] = done;  t_phi[k] = phi;
            t_phib[k] = phib;  t_load[k] = load;  t_si[k]  = scan_in;
            t_sel[k]  = scan_i0o1;
            rd_tr[k]  = rd_data;
            start = (k == s_a) || (k >= s_b && k <= s_b_end);
            mode  = (k >= s_b) ? ~m : m;
            rst   = (k == rst_at);
        end
        start = 1'b0;
        rst   = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        logic seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            seen = done;
        end
        check(tag, {63'd0, seen}, 64'd1);
    endtask

    logic [63:0]  e_phi, e_phib;
    logic [N-1:0] seq;

    initial begin
        #200000;
        $display("FAIL global_timeout got 0 expected 1");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; start = 1'b0; mode = 1'b0; wr_data = '0; par_in = 8'h3C;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        check("idle_outputs", {57'd0, busy, done, phi, phib, load, scan_in, scan_i0o1}, 64'd0);
        check("idle_rd_data", {56'd0, rd_data}, 64'd0);

        // write 0xA5
        run(1'b0, 8'hA5, 54, -1, -1, -1, -1);
        e_phi = '0; e_phib = '0;
        for (int b = 0; b < 8; b++) begin
            e_phi  |= msk(2 + 6*b, 3 + 6*b);
            e_phib |= msk(5 + 6*b, 6 + 6*b);
        end
        for (int b = 0; b < 8; b++) seq[7-b] = t_si[1 + 6*b];
        check("wr_busy",    t_busy, msk(1, 51));
        check("wr_done",    t_done, msk(52, 52));
        check("wr_load",    t_load, msk(50, 51));
        check("wr_phi",     t_phi,  e_phi);
        check("wr_phib",    t_phib, e_phib);
        check("wr_bit0_phi", {56'd0, t_phi[7:0]}, 64'h0C);
        check("wr_scan_seq", {56'd0, seq}, 64'hA5);
        check("wr_sel",     t_sel,  64'd0);
        check("wr_si_tail", {56'd0, t_si[56:49]}, 64'd0);
        check("wr_shadow",  {56'd0, shadow}, 64'hA5);

        // read with chain parallel input 0x3C
        run(1'b1, 8'h00, 57, -1, -1, -1, -1);
        e_phi = '0; e_phib = '0;
        for (int b = 0; b < 9; b++) begin
            e_phi  |= msk(2 + 6*b, 3 + 6*b);
            e_phib |= msk(5 + 6*b, 6 + 6*b);
        end
        check("rd_sel",     t_sel,  msk(1, 6));
        check("rd_busy",    t_busy, msk(1, 55));
        check("rd_done",    t_done, msk(56, 56));
        check("rd_phi",     t_phi,  e_phi);
        check("rd_phib",    t_phib, e_phib);
        check("rd_load",    t_load, 64'd0);
        check("rd_scan_in", t_si,   64'd0);
        check("rd_hold",    {56'd0, rd_tr[55]}, 64'h00);
        check("rd_data",    {56'd0, rd_tr[56]}, 64'h3C);
        check("rd_shadow",  {56'd0, shadow}, 64'hA5);

        // write 0x5A with starts at 10 (busy) and 52 (done), read accepted at 53
        par_in = 8'hC3;
        run(1'b0, 8'h5A, 54, 10, 52, 53, -1);
        check("ign_busy",   t_busy, msk(1, 51) | msk(54, 54));
        check("ign_done",   t_done, msk(52, 52));
        check("ign_shadow", {56'd0, shadow}, 64'h5A);
        wait_done("ign_next_done");
        check("ign_next_rd", {56'd0, rd_data}, 64'hC3);

        // reset in cycle 20 of a write
        run(1'b0, 8'hFF, 30, -1, -1, -1, 20);
        check("rst_quiet", (t_phi | t_phib | t_load | t_busy) & msk(21, 30), 64'd0);
        check("rst_no_done", t_done, 64'd0);
        check("rst_rd_data", {56'd0, rd_tr[21]}, 64'h00);
        run(1'b0, 8'h0F, 1, -1, -1, -1, -1);
        wait_done("rst_next_done");
        @(negedge clk);
        check("rst_next_shadow", {56'd0, shadow}, 64'h0F);

        check("mon_overlap", 64'(v_overlap), 64'd0);
        check("mon_stable",  64'(v_stable),  64'd0);
        check("mon_done_w",  64'(v_done),    64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/scan_chain_ctrl.md
Name: scan_chain_ctrl

Overview:
- Sequencer that drives the on-chip two-phase configuration scan chain of the CNN core: `phi`, `phib`, `scan_i0o1`, `load`, `scan_in`.
- Replaces direct pad-level bit-banging of these signals with a single command interface.
- Write command: serialises a parallel word into the chain, then pulses `load`.
- Read command: captures chain contents, then shifts them out into a parallel word.
- Sits between the host/test-control logic and the scan chain, in the `clk_signal_ext` domain.

Parameters:
- CHAIN_LEN, 64, number of scan chain bits (≥2).
- PH_W, 2, cycles `phi` (or `phib`) is held high per phase (≥1).
- GAP_W, 1, non-overlap cycles with both clocks low (≥1).
- LOAD_W, 2, cycles `load` is held high after a write (≥1).

Ports:
- clk_signal_ext  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  command strobe; accepted only when busy=0.
- mode  in  1  0 = write chain, 1 = read chain; sampled with start.
- wr_data  in  CHAIN_LEN  write word; sampled with start.
- rd_data  out  CHAIN_LEN  last read word.
- busy  out  1  command in progress.
- done  out  1  one-cycle completion pulse.
- phi  out  1  scan master clock.
- phib  out  1  scan slave clock.
- scan_i0o1  out  1  chain capture select.
- load  out  1  chain shadow-register update strobe.
- scan_in  out  1  serial data into chain.
- scan_out  in  1  serial data from chain (last stage).

Behaviour:
- Design is one clock, `clk_signal_ext`; reset `rst` is synchronous and active-high.
- All outputs are registered.
- Reset: state IDLE; all outputs 0, including `rd_data`. Reset mid-command aborts it and drives all scan outputs low on the next cycle; `done` is not pulsed.
- Accept: start=1 in IDLE at edge of cycle 0 latches `mode` and `wr_data`. busy=1 from cycle 1. start while busy is ignored.
- Bit period T = 2·GAP_W + 2·PH_W cycles, in this order:
  - SETUP (GAP_W cycles, clocks low);
  - PHI (PH_W cycles, phi=1);
  - HOLD (GAP_W cycles, clocks low);
  - PHIB (PH_W cycles, phib=1).
- phi and phib are never high in the same cycle.
- `scan_in` and `scan_i0o1` change only on entry to SETUP or TAIL, i.e. while both clocks are low.
- Write (mode=0):
  - CHAIN_LEN bit periods; bit k drives scan_in = wr_data[CHAIN_LEN-1-k] (MSB first) for the whole period; scan_i0o1=0.
  - Then TAIL (GAP_W cycles, all low), then LOAD (load=1 for LOAD_W cycles), then DONE.
  - Busy length = CHAIN_LEN·T + GAP_W + LOAD_W.
- Read (mode=1):
  - One CAPTURE bit period with scan_i0o1=1 and scan_in=0.
  - Then CHAIN_LEN shift periods with scan_i0o1=0 and scan_in=0.
  - In each shift period, `scan_out` is registered at the end of the first SETUP cycle, into an internal shift register filled MSB first (first sample → bit CHAIN_LEN-1).
  - Then TAIL (GAP_W cycles), then DONE. `load` is never asserted in read mode.
  - Busy length = (CHAIN_LEN+1)·T + GAP_W.
- DONE lasts one cycle: done=1, busy=0, all scan outputs 0.
  - Read only: rd_data is updated from the shift register in this cycle; it holds otherwise.
  - Next cycle: IDLE. start in the DONE cycle is ignored; the earliest accept is the first IDLE cycle.
- Counters: a phase-cycle counter of width clog2(max(PH_W,GAP_W,LOAD_W)) and a bit counter of width clog2(CHAIN_LEN+1). Both wrap to 0 on each phase/bit transition.

Test Plan (bench uses CHAIN_LEN=8, PH_W=2, GAP_W=1, LOAD_W=2, T=6; behavioural two-phase chain model):
- Reset then idle 10 cycles → all outputs 0; rd_data=0x00.
- Write 0xA5, start at cycle 0:
  - busy=1 in cycles 1–51;
  - scan_in bit sequence 1,0,1,0,0,1,0,1;
  - bit 0: phi=1 in cycles 2–3, phib=1 in cycles 5–6;
  - load=1 in cycles 50–51; done=1 and busy=0 in cycle 52;
  - model shadow register = 0xA5.
- Read with model parallel input 0x3C, start at cycle 0:
  - scan_i0o1=1 in cycles 1–6 only;
  - busy=1 in cycles 1–55; done in cycle 56 with rd_data=0x3C;
  - load never high; model shadow register unchanged.
- start pulsed at cycles 10 and 52 during a write from cycle 0 → both ignored; only one done; the next command is accepted at cycle 53.
- rst asserted at cycle 20 of a write → from cycle 21 phi=phib=load=busy=0; no done; a following write of 0x0F completes with shadow register 0x0F.
- Assertion over all tests: never phi&phib; scan_in/scan_i0o1 stable while phi|phib=1; done is exactly one cycle wide.
